// File: rtl/sipo_rx_if.sv
// Bundles the serial input side and the parallel word output side of sipo_rx.
//   master : drives sin/sin_valid/start/out_ready, observes word and status
//   slave  : the deserializer itself
//   sin, sin_valid, start : serial bit, its qualifier, frame-start marker
//   out_data, out_valid, out_ready : word port with valid/ready handshake
//   busy, overrun, resync : frame in progress, sticky drop flag, resync pulse
interface sipo_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sin;
    logic             sin_valid;
    logic             start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             resync;

    modport master (
        output sin, sin_valid, start, out_ready,
        input  out_data, out_valid, busy, overrun, resync
    );

    modport slave (
        input  sin, sin_valid, start, out_ready,
        output out_data, out_valid, busy, overrun, resync
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in parallel-out deserializer: receive end of the PISO link.
// Samples one bit per sin_valid edge, frames on start, and presents each
// WIDTH-bit word on a valid/ready port with overrun and resync reporting.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : sipo_rx_if slave modport (serial in, word out, status)
module sipo_rx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sipo_rx_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               resync_q, resync_d;
    logic [WIDTH-1:0]   base_c;
    logic [WIDTH-1:0]   shifted_c;

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        resync_d = 1'b0;

        // A start bit always shifts into an empty register.
        base_c = bus.start ? '0 : shift_q;
        if (MSB_FIRST) begin
            shifted_c = {base_c[WIDTH-2:0], bus.sin};
        end else begin
            shifted_c = {bus.sin, base_c[WIDTH-1:1]};
        end

        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        if (bus.sin_valid) begin
            if (bus.start) begin
                shift_d  = shifted_c;
                cnt_d    = CNT_W'(1);
                state_d  = SHIFT;
                resync_d = (state_q == SHIFT);
            end else if (state_q == SHIFT) begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shift_d = '0;
                    // Slot is free if empty or being drained on this edge.
                    if (!valid_q || bus.out_ready) begin
                        data_d  = shifted_c;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    shift_d = shifted_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            resync_q <= resync_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.overrun   = ovr_q;
    assign bus.resync    = resync_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: a vector table for the MSB-first instance plus
// hand-written sequences for async reset and LSB-first ordering.
module tb_sipo_rx;
    logic clk;
    logic rst;

    sipo_rx_if #(.WIDTH(8)) m_if ();
    sipo_rx_if #(.WIDTH(8)) l_if ();

    sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic       st;
        logic       s;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
        logic       er;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic add(input logic sv, st, s, rdy, ev, input logic [7:0] ed,
                       input logic eb, eo, er);
        vec_t v;
        v.sv = sv; v.st = st; v.s = s; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic sv, st, s, rdy);
        m_if.sin_valid = sv; m_if.start = st; m_if.sin = s; m_if.out_ready = rdy;
        l_if.sin_valid = sv; l_if.start = st; l_if.sin = s; l_if.out_ready = rdy;
    endtask

    // Packed view: {valid, data[7:0], busy, overrun, resync}
    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got valid=%0b data=%02h busy=%0b ovr=%0b rs=%0b, want valid=%0b data=%02h busy=%0b ovr=%0b rs=%0b",
                     name, got[11], got[10:3], got[2], got[1], got[0],
                     exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [11:0] snap_m();
        return {m_if.out_valid, m_if.out_data, m_if.busy, m_if.overrun, m_if.resync};
    endfunction

    function automatic logic [11:0] snap_l();
        return {l_if.out_valid, l_if.out_data, l_if.busy, l_if.overrun, l_if.resync};
    endfunction

    initial begin
        // Basic 0xA5 = 1,0,1,0,0,1,0,1
        add(1,1,1,0, 0,8'h00,1,0,0);
        add(1,0,0,0, 0,8'h00,1,0,0);
        add(1,0,1,0, 0,8'h00,1,0,0);
        add(1,0,0,0, 0,8'h00,1,0,0);
        add(1,0,0,0, 0,8'h00,1,0,0);
        add(1,0,1,0, 0,8'h00,1,0,0);
        add(1,0,0,0, 0,8'h00,1,0,0);
        add(1,0,1,0, 1,8'hA5,0,0,0);
        add(0,0,0,1, 0,8'hA5,0,0,0);
        add(1,0,1,0, 0,8'hA5,0,0,0);   // bit without start in IDLE ignored
        // Gapped 0xA5, start asserted during the gap must be ignored
        add(1,1,1,0, 0,8'hA5,1,0,0);
        add(1,0,0,0, 0,8'hA5,1,0,0);
        add(1,0,1,0, 0,8'hA5,1,0,0);
        add(1,0,0,0, 0,8'hA5,1,0,0);
        add(0,1,1,0, 0,8'hA5,1,0,0);
        add(0,1,1,0, 0,8'hA5,1,0,0);
        add(0,1,1,0, 0,8'hA5,1,0,0);
        add(1,0,0,0, 0,8'hA5,1,0,0);
        add(1,0,1,0, 0,8'hA5,1,0,0);
        add(1,0,0,0, 0,8'hA5,1,0,0);
        add(1,0,1,0, 1,8'hA5,0,0,0);
        add(0,0,0,1, 0,8'hA5,0,0,0);
        // Back-to-back 0x11 (ready=1) then 0x22, accept on completion edge
        add(1,1,0,1, 0,8'hA5,1,0,0);
        add(1,0,0,1, 0,8'hA5,1,0,0);
        add(1,0,0,1, 0,8'hA5,1,0,0);
        add(1,0,1,1, 0,8'hA5,1,0,0);
        add(1,0,0,1, 0,8'hA5,1,0,0);
        add(1,0,0,1, 0,8'hA5,1,0,0);
        add(1,0,0,1, 0,8'hA5,1,0,0);
        add(1,0,1,1, 1,8'h11,0,0,0);
        add(1,1,0,0, 1,8'h11,1,0,0);
        add(1,0,0,0, 1,8'h11,1,0,0);
        add(1,0,1,0, 1,8'h11,1,0,0);
        add(1,0,0,0, 1,8'h11,1,0,0);
        add(1,0,0,0, 1,8'h11,1,0,0);
        add(1,0,0,0, 1,8'h11,1,0,0);
        add(1,0,1,0, 1,8'h11,1,0,0);
        add(1,0,0,1, 1,8'h22,0,0,0);
        add(0,0,0,1, 0,8'h22,0,0,0);
        // Resync after 5 bits, then 0x96 = 1,0,0,1,0,1,1,0
        add(1,1,1,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,1,1,0, 0,8'h22,1,0,1);
        add(1,0,0,0, 0,8'h22,1,0,0);
        add(1,0,0,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,0,0,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,0,1,0, 0,8'h22,1,0,0);
        add(1,0,0,0, 1,8'h96,0,0,0);
        add(0,0,0,1, 0,8'h96,0,0,0);
        // Overrun: 0x3C completes, 0xFF completes while not accepted
        add(1,1,0,0, 0,8'h96,1,0,0);
        add(1,0,0,0, 0,8'h96,1,0,0);
        add(1,0,1,0, 0,8'h96,1,0,0);
        add(1,0,1,0, 0,8'h96,1,0,0);
        add(1,0,1,0, 0,8'h96,1,0,0);
        add(1,0,1,0, 0,8'h96,1,0,0);
        add(1,0,0,0, 0,8'h96,1,0,0);
        add(1,0,0,0, 1,8'h3C,0,0,0);
        add(1,1,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,1,0,0);
        add(1,0,1,0, 1,8'h3C,0,1,0);
        add(0,0,0,1, 0,8'h3C,0,1,0);
        add(0,0,0,1, 0,8'h3C,0,1,0);

        rst = 1'b0;
        drive(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 check("reset_state", snap_m(), 12'h000);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sv, tbl[i].st, tbl[i].s, tbl[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), snap_m(),
                  {tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].eo, tbl[i].er});
        end

        // Async reset mid-frame: outputs clear with no clock edge
        drive(1, 1, 1, 0);
        @(posedge clk);
        #1 drive(1, 0, 1, 0);
        @(posedge clk);
        #1 check("pre_reset", snap_m(), {1'b0, 8'h3C, 1'b1, 1'b1, 1'b0});
        #1 rst = 1'b1;
        #1 check("async_reset", snap_m(), 12'h000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Same bits 1,1,0,0,0,0,0,0 into both bit orders
        drive(1, 1, 1, 0);
        @(posedge clk);
        #1 drive(1, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1 drive(1, 0, 0, 0);
        end
        // Loop above applied 1,1 then 0 x6 over 8 edges
        check("msb_first_c0", snap_m(), {1'b1, 8'hC0, 1'b0, 1'b0, 1'b0});
        check("lsb_first_03", snap_l(), {1'b1, 8'h03, 1'b0, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-in parallel-out deserializer. It is the receive end of the team's PISO shift-register link. It samples one serial bit per qualified clock, assembles a WIDTH-bit word, and presents it on a valid/ready output port. Framing is by an explicit start strobe on the first bit. Overrun and resync errors are flagged.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 means the first received bit lands in out_data[WIDTH-1]; 0 means the first bit lands in out_data[0].

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled only on edges where this is 1.
start  input  1  marks the current sin bit as bit 1 of a frame; ignored unless sin_valid=1.
out_data  output  WIDTH  last completed word.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts out_data on an edge where out_valid=1 and out_ready=1.
busy  output  1  frame in progress (state SHIFT).
overrun  output  1  sticky; a completed word was dropped.
resync  output  1  one-cycle pulse; a partial frame was discarded by start.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift reg=0, bit count=0, out_data=0, out_valid=0, busy=0, overrun=0, resync=0. Reset mid-frame discards the partial word immediately, without waiting for clk.
- Bit count width is clog2(WIDTH+1). All other registers are plain shift/hold with no arithmetic beyond the count increment.
- IDLE state:
  - sin_valid=1 and start=1: shift in sin as bit 1, count=1, go to SHIFT.
  - sin_valid=1 and start=0: bit ignored, stay in IDLE.
- SHIFT state:
  - sin_valid=0: hold all state.
  - sin_valid=1 and start=0: shift in sin, count+1.
  - sin_valid=1 and start=1: discard the partial word, take sin as bit 1, count=1, stay in SHIFT, resync=1 for one cycle.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
  - After WIDTH bits the first bit therefore sits at out_data[WIDTH-1] or out_data[0] respectively.
- Completion: on the edge that samples bit WIDTH, the full word, including that bit, is written to out_data. state becomes IDLE and count=0. Latency is 0 cycles from last-bit edge to out_valid=1, i.e. visible immediately after that edge.
- Output handshake:
  - out_valid stays 1 and out_data is stable until an edge with out_ready=1, which clears out_valid.
  - out_ready while out_valid=0 has no effect.
- Simultaneous completion and accept (out_valid=1, out_ready=1, word completes on the same edge): new word loads, out_valid stays 1, no overrun.
- Overrun (word completes while out_valid=1 and out_ready=0): new word dropped, out_data unchanged, overrun set to 1. It stays 1 until rst.
- resync is 0 on every edge except the resync case above.
- busy = (state==SHIFT).
- A new frame may begin on the edge right after completion: IDLE plus start is accepted immediately, giving back-to-back words every WIDTH qualified bits.

Test Plan:
- Basic, WIDTH=8, MSB_FIRST=1: start with bit 1, then sin=1,0,1,0,0,1,0,1 on 8 consecutive sin_valid edges -> out_data=8'hA5, out_valid=1 after 8th edge, busy 1 then 0; out_ready=1 one cycle later clears out_valid.
- LSB-first, MSB_FIRST=0: same bit sequence -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome check invalid), so use 1,1,0,0,0,0,0,0 -> out_data=8'h03; with MSB_FIRST=1 the same bits give 8'hC0.
- Gapped input: 0xA5 frame with sin_valid low for 3 cycles between bits 4 and 5 -> identical 8'hA5, completion delayed by 3 cycles; no bits sampled while sin_valid=0; bits with sin_valid=1 and start=0 in IDLE are ignored.
- Overrun: 0x3C completes, out_ready held 0, frame 0xFF completes -> out_data stays 8'h3C, overrun=1; then out_ready=1 -> out_valid=0, overrun remains 1 until rst.
- Back-to-back with accept: out_ready tied 1, frames 0x11 then 0x22 contiguous -> out_valid continuous across second completion edge, out_data 8'h11 then 8'h22, overrun=0.
- Resync and reset: start reasserted after 5 bits -> resync pulse 1 cycle, next 8 bits form the word. Separately, assert rst mid-frame between clock edges -> busy, out_valid, and out_data go 0 immediately.
